// File: rtl/pe_mac_bank.sv
// Fixed-point MAC processing element with a bank of indexed accumulators.
// Products accumulate per index; a "last" term rounds, saturates and emits the sum.
module pe_mac_bank #(
  parameter int unsigned INT_BITS  = 7,
  parameter int unsigned FRAC_BITS = 9,
  parameter int unsigned ACC_DEPTH = 8,
  parameter int unsigned ACC_GUARD = 4,
  localparam int unsigned W        = INT_BITS + FRAC_BITS,
  localparam int unsigned IW       = $clog2(ACC_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          in_valid,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [IW-1:0] in_idx,
  input  logic          in_last,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_sat
);

  localparam int unsigned PW  = 2 * W;
  localparam int unsigned AW  = PW + ACC_GUARD;
  localparam int unsigned AW1 = AW + 1;

  localparam logic        [AW:0] HALF  = AW1'(1) << (FRAC_BITS - 1);
  localparam logic signed [AW:0] MAX_R = AW1'((64'd1 << (W - 1)) - 64'd1);
  localparam logic signed [AW:0] MIN_R = ~MAX_R;

  // S1: registered product
  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic [IW-1:0]        s1_idx_q;
  logic signed [PW-1:0] s1_prod_q;
  logic signed [PW-1:0] prod_c;

  // S2/S3: accumulator bank and captured final sum
  logic [AW-1:0]        acc_q [ACC_DEPTH];
  logic [AW-1:0]        sum_c;
  logic                 s3_valid_q;
  logic [AW-1:0]        s3_sum_q;
  logic [IW-1:0]        s3_idx_q;

  // Output registers
  logic                 out_valid_q;
  logic [W-1:0]         out_data_q;
  logic [IW-1:0]        out_idx_q;
  logic                 out_sat_q;

  logic [AW:0]          rnd_sum_c;
  logic signed [AW:0]   rnd_c;
  logic [W-1:0]         sat_data_c;
  logic                 sat_c;

  assign prod_c = PW'($signed(in_a)) * PW'($signed(in_b));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_prod_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid & in_last;
      s1_idx_q   <= in_idx;
      s1_prod_q  <= prod_c;
    end
  end

  assign sum_c = acc_q[s1_idx_q] + AW'(s1_prod_q);

  // Single-cycle read-modify-write; a last term clears instead of writing back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '{default: '0};
      s3_valid_q <= 1'b0;
      s3_sum_q   <= '0;
      s3_idx_q   <= '0;
    end else if (!stall) begin
      s3_valid_q <= s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        if (s1_last_q) begin
          acc_q[s1_idx_q] <= '0;
          s3_sum_q        <= sum_c;
          s3_idx_q        <= s1_idx_q;
        end else begin
          acc_q[s1_idx_q] <= sum_c;
        end
      end
    end
  end

  // Round half toward +inf, then clip to the operand format
  always_comb begin
    rnd_sum_c  = {s3_sum_q[AW-1], s3_sum_q} + HALF;
    rnd_c      = $signed(rnd_sum_c) >>> FRAC_BITS;
    sat_c      = 1'b0;
    sat_data_c = rnd_c[W-1:0];
    if (rnd_c > MAX_R) begin
      sat_c      = 1'b1;
      sat_data_c = MAX_R[W-1:0];
    end else if (rnd_c < MIN_R) begin
      sat_c      = 1'b1;
      sat_data_c = MIN_R[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_sat_q   <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        out_data_q <= sat_data_c;
        out_idx_q  <= s3_idx_q;
        out_sat_q  <= sat_c;
      end
    end
  end

  // A result held through a stall is re-presented once stall drops
  assign out_valid = out_valid_q & ~stall;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pe_mac_bank.sv
// Directed and random checks of pe_mac_bank against an arithmetic reference model.
module tb_pe_mac_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_idx;
  logic        in_last;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  pe_mac_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_idx    (in_idx),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Reference state: integer accumulators and in-flight terms
  longint      acc_m [8];
  bit          p1_v, p1_l;
  int          p1_idx;
  longint      p1_prod;
  bit          p3_v;
  int          p3_idx;
  longint      p3_sum;
  bit          o_v;
  logic [15:0] o_d;
  logic [2:0]  o_i;
  bit          o_s;

  function automatic longint wrap36(longint x);
    return (x <<< 28) >>> 28;
  endfunction

  function automatic void round_sat(longint s, output logic [15:0] d, output bit sat);
    longint r;
    r = (s + 256) >>> 9;
    if (r > 32767) begin
      d = 16'h7FFF; sat = 1'b1;
    end else if (r < -32768) begin
      d = 16'h8000; sat = 1'b1;
    end else begin
      d = 16'(r); sat = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    logic [15:0] d;
    bit          s;
    longint      sum;
    if (!rst_n) begin
      foreach (acc_m[i]) acc_m[i] = 0;
      p1_v = 0; p1_l = 0; p1_idx = 0; p1_prod = 0;
      p3_v = 0; p3_idx = 0; p3_sum = 0;
      o_v = 0; o_d = '0; o_i = '0; o_s = 0;
    end else if (!stall) begin
      if (p3_v) begin
        round_sat(p3_sum, d, s);
        o_d = d; o_s = s; o_i = 3'(p3_idx);
      end
      o_v  = p3_v;
      p3_v = p1_v && p1_l;
      if (p1_v) begin
        sum = wrap36(acc_m[p1_idx] + p1_prod);
        if (p1_l) begin
          p3_sum = sum; p3_idx = p1_idx; acc_m[p1_idx] = 0;
        end else begin
          acc_m[p1_idx] = sum;
        end
      end
      p1_v    = in_valid;
      p1_l    = in_last;
      p1_idx  = int'(in_idx);
      p1_prod = longint'($signed(in_a)) * longint'($signed(in_b));
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] idx, input bit last, input bit st, input bit rn);
    in_valid = v; in_a = a; in_b = b; in_idx = idx; in_last = last;
    stall = st; rst_n = rn;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 32'(out_valid), 32'(o_v & ~stall));
    if (o_v && !stall) begin
      chk("out_data", 32'(out_data), 32'(o_d));
      chk("out_idx", 32'(out_idx), 32'(o_i));
      chk("out_sat", 32'(out_sat), 32'(o_s));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0, '0, 0, 0, 1);
  endtask

  // Issue one last term, wait out the latency and check the result as constants
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] idx, input logic [15:0] exp_d, input bit exp_s);
    step(1, a, b, idx, 1, 0, 1);
    idle(2);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_idx"}, 32'(out_idx), 32'(idx));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
    idle(1);
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    step(0, '0, '0, '0, 0, 0, 0);
    step(0, '0, '0, '0, 0, 0, 0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);

    single("unit", 16'h0200, 16'h0200, 3'd0, 16'h0200, 1'b0);
    single("unit_again", 16'h0200, 16'h0200, 3'd0, 16'h0200, 1'b0);

    // Two-term chain on idx 5
    step(1, 16'h0300, 16'h0400, 3'd5, 0, 0, 1);
    step(1, 16'h0200, 16'h0200, 3'd5, 1, 0, 1);
    idle(1);
    chk("chain_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("chain_data", 32'(out_data), 32'h0800);
    chk("chain_idx", 32'(out_idx), 32'd5);

    single("rnd_half", 16'h0001, 16'h0100, 3'd1, 16'h0001, 1'b0);
    single("rnd_below", 16'h0001, 16'h00FF, 3'd1, 16'h0000, 1'b0);
    single("rnd_neg", 16'hFFFF, 16'h0100, 3'd1, 16'h0000, 1'b0);
    single("sat_pos", 16'h7FFF, 16'h7FFF, 3'd6, 16'h7FFF, 1'b1);
    single("sat_neg", 16'h8000, 16'h7FFF, 3'd7, 16'h8000, 1'b1);

    // Interleave idx 0 and 3
    step(1, 16'h0200, 16'h0200, 3'd0, 0, 0, 1);
    step(1, 16'h0200, 16'h0200, 3'd3, 0, 0, 1);
    step(1, 16'h0200, 16'h0200, 3'd0, 1, 0, 1);
    step(1, 16'h0200, 16'h0200, 3'd3, 1, 0, 1);
    idle(1);
    chk("ilv0_data", 32'(out_data), 32'h0400);
    chk("ilv0_idx", 32'(out_idx), 32'd0);
    idle(1);
    chk("ilv3_valid", 32'(out_valid), 32'd1);
    chk("ilv3_data", 32'(out_data), 32'h0400);
    chk("ilv3_idx", 32'(out_idx), 32'd3);

    // Stall three cycles with a last term waiting to accumulate
    step(1, 16'h0200, 16'h0200, 3'd2, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 16'h7FFF, 16'h7FFF, 3'd2, 1, 1, 1);
      chk("stall_quiet", 32'(out_valid), 32'd0);
    end
    idle(2);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'h0200);
    chk("stall_idx", 32'(out_idx), 32'd2);

    // Reset mid-chain, asserted together with stall
    step(1, 16'h0300, 16'h0300, 3'd4, 0, 0, 1);
    step(1, 16'h0300, 16'h0300, 3'd4, 0, 0, 1);
    step(1, 16'h0300, 16'h0300, 3'd4, 0, 1, 0);
    single("rst_chain", 16'h0200, 16'h0200, 3'd4, 16'h0200, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = 16'($urandom); rb = 16'($urandom);
      end else begin
        ra = 16'(int'($urandom_range(0, 2047)) - 1024);
        rb = 16'(int'($urandom_range(0, 2047)) - 1024);
      end
      step($urandom_range(0, 9) < 8, ra, rb, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 99) != 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
